// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// All segment/anode encodings are active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // {g,f,e,d,c,b,a}, active-low, indexed by hex nibble
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver with anti-ghost blanking,
// frame-aligned shadow registers and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  scan_state_t   state, state_nxt;

  logic [31:0] sh_val;
  logic [7:0]  sh_dp, sh_en;
  logic        sh_lz;

  logic       wrap, boundary, dark;
  logic [7:0] upper_zero;
  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic [7:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign wrap       = (cnt == CW'(DIGIT_CYCLES - 1));
  assign boundary   = wrap && (idx == 3'd7);
  assign frame_done = boundary;

  always_comb begin
    cnt_nxt   = wrap ? '0 : cnt + CW'(1);
    idx_nxt   = wrap ? idx + 3'd1 : idx;
    state_nxt = (cnt_nxt < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      idx   <= '0;
      state <= ST_BLANK;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
    end
  end

  // Inputs are sampled only at the frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_val <= '0;
      sh_dp  <= '0;
      sh_en  <= '0;
      sh_lz  <= 1'b0;
    end else if (boundary) begin
      sh_val <= value;
      sh_dp  <= dp_mask;
      sh_en  <= digit_en;
      sh_lz  <= blank_lz;
    end
  end

  // upper_zero[i]: nibbles i..7 are all zero
  for (genvar i = 0; i < 8; i++) begin : g_lz
    assign upper_zero[i] = (sh_val[31:4*i] == '0);
  end

  assign nib  = sh_val[idx*4 +: 4];
  assign dark = !sh_en[idx] || (sh_lz && (idx != 3'd0) && upper_zero[idx]);

  seg7_hex_decode u_dec (
    .nib (nib),
    .seg (hex_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (state == ST_DRIVE && !dark) begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = hex_seg;
      dp_nxt  = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame/position-based model.
module tb_seg7_scan_driver;

  localparam int D = 8;
  localparam int B = 2;
  localparam int FRAME = 8 * D;
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  digit_en = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int nchk = 0;
  int nerr = 0;

  seg7_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .value      (value),
    .dp_mask    (dp_mask),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: n = clocks since reset release; slot position = n mod FRAME.
  int          n = 0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_dp = '0, m_en = '0;
  logic        m_lz = 1'b0;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fd = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        n = 0; m_val = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else begin
        int p, d, c;
        bit lit;
        p = n % FRAME;
        d = p / D;
        c = p % D;
        lit = (c >= B) && m_en[d] && !(m_lz && d > 0 && (m_val >> (4 * d)) == 0);
        e_an  = lit ? ~(8'd1 << d) : 8'hFF;
        e_seg = lit ? HEX[(m_val >> (4 * d)) & 32'hF] : 7'h7F;
        e_dp  = lit ? ~m_dp[d] : 1'b1;
        if (p == FRAME - 1) begin
          m_val = value; m_dp = dp_mask; m_en = digit_en; m_lz = blank_lz;
        end
        n++;
        e_fd = (n % FRAME) == FRAME - 1;
      end
    end
  end

  // Per-clock comparison plus one-hot and blanking-gap invariants.
  initial begin
    int last_dig = -1;
    int gap = 0;
    forever begin
      @(negedge clk);
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("frame_done", frame_done, e_fd);
      chk("onehot", ($countones(~an) <= 1), 1);
      if (!resetn) begin
        last_dig = -1;
        gap = 0;
      end else if (an == 8'hFF) begin
        gap++;
      end else begin
        int dg = 0;
        for (int i = 0; i < 8; i++) if (!an[i]) dg = i;
        if (last_dig >= 0 && dg != last_dig) chk("gap", (gap >= B), 1);
        last_dig = dg;
        gap = 0;
      end
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_pos(input int k);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (n % FRAME == k) return;
      @(negedge clk);
    end
    chk("wait_timeout", 0, 1);
  endtask

  initial begin
    value = 32'h89AB_CDEF; digit_en = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    run(3);
    resetn = 1'b1;
    run(2 * FRAME + 4);

    value = 32'h0;
    wait_pos(FRAME - 4);
    run(4);
    wait_pos(FRAME / 2);
    value = 32'h1111_1111;
    run(FRAME + FRAME / 2 + 4);

    value = 32'h0000_0305; blank_lz = 1'b1;
    run(2 * FRAME);
    value = 32'h0;
    run(2 * FRAME);

    value = $urandom; blank_lz = 1'b0; digit_en = 8'h0F; dp_mask = 8'h05;
    run(2 * FRAME);

    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 15))
        0: value    = $urandom;
        1: dp_mask  = 8'($urandom);
        2: digit_en = 8'($urandom);
        3: blank_lz = 1'($urandom);
        4: value    = $urandom & 32'h0000_0FFF;
        default: ;
      endcase
    end

    value = 32'h1234_5678; digit_en = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    run(2 * FRAME);
    wait_pos(3 * D + 4);
    chk("pre_rst_lit", an, 8'hF7);
    #2 resetn = 1'b0;
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    run(3);
    resetn = 1'b1;
    value = $urandom; digit_en = 8'hFF; dp_mask = 8'($urandom);
    run(2 * FRAME + 8);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
